id_ex_pipe_reg: RTL and testbench



---
 rtl/id_ex_pipe_reg_if.sv | 16 +
 rtl/id_ex_pipe_reg.sv | 143 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// Valid/ready stream carrying one ID->EX instruction: control bundle, flags snapshot, payload.
// The master drives valid/ctrl/sr/data and the slave drives ready.
interface id_ex_pipe_reg_if #(
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned SR_W   = 4,
    parameter int unsigned DATA_W = 128
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [SR_W-1:0]   sr;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output sr, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  sr, input  data, output ready);
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready on both sides, synchronous flush and a control
// bundle forced to zero on bubbles. Define IDREG_SKID_EN for the two-entry skid variant.
module id_ex_pipe_reg #(
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned SR_W   = 4,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    id_ex_pipe_reg_if.slave   in_if,
    id_ex_pipe_reg_if.master  out_if
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [SR_W-1:0]   r_main_sr;
    logic [DATA_W-1:0] r_main_data;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_ld_main_in;

`ifdef IDREG_SKID_EN
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [SR_W-1:0]   r_skid_sr;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_ld_main_skid;
    logic              w_ld_skid;

    // Registered ready: decode never sees a combinational path from out_ready.
    assign w_in_ready = r_in_ready;
`else
    assign w_in_ready = !r_out_valid || out_if.ready;
`endif

    assign w_in_xfer  = in_if.valid && w_in_ready;
    assign w_out_xfer = r_out_valid && out_if.ready;

    assign in_if.ready  = w_in_ready;
    assign out_if.valid = r_out_valid;
    assign out_if.ctrl  = r_main_ctrl;
    assign out_if.sr    = r_main_sr;
    assign out_if.data  = r_main_data;

    // Next-state and load selects; flush overrides every handshake.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
`ifdef IDREG_SKID_EN
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
`endif
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_ld_main_in = 1'b1;
`ifdef IDREG_SKID_EN
                    end else if (w_in_xfer) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = ST_FULL;
`endif
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
`ifdef IDREG_SKID_EN
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = ST_HALF;
                    end
                end
`endif
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Main entry drives the outputs; ctrl is cleared whenever the register goes empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
            r_main_sr   <= '0;
            r_main_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            if (w_ld_main_in) begin
                r_main_ctrl <= in_if.ctrl;
                r_main_sr   <= in_if.sr;
                r_main_data <= in_if.data;
`ifdef IDREG_SKID_EN
            end else if (w_ld_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_sr   <= r_skid_sr;
                r_main_data <= r_skid_data;
`endif
            end else if (w_state_nxt == ST_EMPTY) begin
                r_main_ctrl <= '0;
            end
        end
    end

`ifdef IDREG_SKID_EN
    // Skid entry holds the second instruction while execute is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_skid_ctrl <= '0;
            r_skid_sr   <= '0;
            r_skid_data <= '0;
        end else begin
            r_in_ready <= (w_state_nxt != ST_FULL);
            if (w_ld_skid) begin
                r_skid_ctrl <= in_if.ctrl;
                r_skid_sr   <= in_if.sr;
                r_skid_data <= in_if.data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: the driver queues every accepted instruction and a
// monitor pops and compares on each output transfer. Works with or without IDREG_SKID_EN.
module tb_id_ex_pipe_reg;
    localparam int unsigned CTRL_W = 10;
    localparam int unsigned SR_W   = 4;
    localparam int unsigned DATA_W = 128;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [SR_W-1:0]   sr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   n_checks;
    int   n_fail;
    exp_t q[$];
    exp_t m_exp;
    logic acc;

    id_ex_pipe_reg_if #(.CTRL_W(CTRL_W), .SR_W(SR_W), .DATA_W(DATA_W)) in_if ();
    id_ex_pipe_reg_if #(.CTRL_W(CTRL_W), .SR_W(SR_W), .DATA_W(DATA_W)) out_if ();

    id_ex_pipe_reg #(.CTRL_W(CTRL_W), .SR_W(SR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .in_if  (in_if),
        .out_if (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction for one cycle; returns whether it was accepted.
    task automatic send(input logic [CTRL_W-1:0] c, input logic [SR_W-1:0] s,
                        input logic [DATA_W-1:0] d, input logic fl, output logic accepted);
        exp_t e;
        in_if.valid = 1'b1;
        in_if.ctrl  = c;
        in_if.sr    = s;
        in_if.data  = d;
        flush       = fl;
        @(negedge clk);
        #1;
        accepted = in_if.ready;
        if (fl) begin
            q.delete();
        end else if (accepted) begin
            e.ctrl = c;
            e.sr   = s;
            e.data = d;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic idle(input int n);
        in_if.valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest queued instruction.
    always @(negedge clk) begin
        if (!rst) begin
            if (!out_if.valid) begin
                chk("bubble_ctrl", DATA_W'(out_if.ctrl), DATA_W'(0));
            end else if (out_if.ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data %0h expected no transfer at %0t",
                             out_if.data, $time);
                end else begin
                    m_exp = q.pop_front();
                    chk("out_data", out_if.data, m_exp.data);
                    chk("out_ctrl", DATA_W'(out_if.ctrl), DATA_W'(m_exp.ctrl));
                    chk("out_sr", DATA_W'(out_if.sr), DATA_W'(m_exp.sr));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.ctrl   = '0;
        in_if.sr     = '0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_valid", DATA_W'(out_if.valid), DATA_W'(0));
        chk("rst_ctrl", DATA_W'(out_if.ctrl), DATA_W'(0));
        chk("rst_sr", DATA_W'(out_if.sr), DATA_W'(0));
        chk("rst_data", out_if.data, DATA_W'(0));
        chk("rst_in_ready", DATA_W'(in_if.ready), DATA_W'(1));

        // Streaming: one per cycle, one cycle latency
        out_if.ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            send(10'h3FF, 4'hA, DATA_W'(k), 1'b0, acc);
            chk("stream_acc", DATA_W'(acc), DATA_W'(1));
            chk("stream_valid", DATA_W'(out_if.valid), DATA_W'(1));
            chk("stream_data", out_if.data, DATA_W'(k));
        end

        // Bubble gating: last entry drained, payload stays stale
        idle(1);
        chk("bubble_valid", DATA_W'(out_if.valid), DATA_W'(0));
        chk("bubble_ctrl0", DATA_W'(out_if.ctrl), DATA_W'(0));
        chk("bubble_data", out_if.data, DATA_W'(3));

        // Stall: push A then B with execute blocked
        out_if.ready = 1'b0;
        send(10'h155, 4'h5, DATA_W'('hA), 1'b0, acc);
        chk("stall_acc_a", DATA_W'(acc), DATA_W'(1));
`ifdef IDREG_SKID_EN
        chk("stall_ready_a", DATA_W'(in_if.ready), DATA_W'(1));
        send(10'h0AA, 4'h3, DATA_W'('hB), 1'b0, acc);
        chk("stall_acc_b", DATA_W'(acc), DATA_W'(1));
        chk("stall_ready_b", DATA_W'(in_if.ready), DATA_W'(0));
        chk("stall_hold_a", out_if.data, DATA_W'('hA));
        out_if.ready = 1'b1;
        idle(1);
`else
        chk("stall_ready_a", DATA_W'(in_if.ready), DATA_W'(0));
        send(10'h0AA, 4'h3, DATA_W'('hB), 1'b0, acc);
        chk("stall_acc_b", DATA_W'(acc), DATA_W'(0));
        chk("stall_hold_a", out_if.data, DATA_W'('hA));
        out_if.ready = 1'b1;
        send(10'h0AA, 4'h3, DATA_W'('hB), 1'b0, acc);
        chk("stall_retry_b", DATA_W'(acc), DATA_W'(1));
`endif
        chk("stall_data_b", out_if.data, DATA_W'('hB));
        idle(1);
        chk("stall_drained", DATA_W'(out_if.valid), DATA_W'(0));

        // Flush while holding everything, with C offered in the same cycle
        out_if.ready = 1'b0;
        send(10'h001, 4'h1, DATA_W'('h21), 1'b0, acc);
`ifdef IDREG_SKID_EN
        send(10'h002, 4'h2, DATA_W'('h22), 1'b0, acc);
`endif
        send(10'h3FF, 4'hF, DATA_W'('hC), 1'b1, acc);
        chk("flush_valid", DATA_W'(out_if.valid), DATA_W'(0));
        chk("flush_ctrl", DATA_W'(out_if.ctrl), DATA_W'(0));
        chk("flush_in_ready", DATA_W'(in_if.ready), DATA_W'(1));
        out_if.ready = 1'b1;
        idle(3);
        chk("flush_no_c", DATA_W'(out_if.valid), DATA_W'(0));

        // Flush when empty discards an accepted input
        send(10'h0F0, 4'h9, DATA_W'('hE), 1'b1, acc);
        chk("flush_empty_valid", DATA_W'(out_if.valid), DATA_W'(0));
        idle(2);

        // Reset in the middle of a stall
        out_if.ready = 1'b0;
        send(10'h011, 4'h7, DATA_W'('h31), 1'b0, acc);
`ifdef IDREG_SKID_EN
        send(10'h022, 4'h8, DATA_W'('h32), 1'b0, acc);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        chk("mrst_valid", DATA_W'(out_if.valid), DATA_W'(0));
        chk("mrst_ctrl", DATA_W'(out_if.ctrl), DATA_W'(0));
        chk("mrst_sr", DATA_W'(out_if.sr), DATA_W'(0));
        chk("mrst_data", out_if.data, DATA_W'(0));
        chk("mrst_in_ready", DATA_W'(in_if.ready), DATA_W'(1));
        out_if.ready = 1'b1;
        send(10'h3C0, 4'h6, DATA_W'('hD), 1'b0, acc);
        chk("mrst_acc_d", DATA_W'(acc), DATA_W'(1));
        chk("mrst_data_d", out_if.data, DATA_W'('hD));
        idle(2);
        chk("mrst_alone", DATA_W'(out_if.valid), DATA_W'(0));
        chk("queue_empty", DATA_W'(q.size()), DATA_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
